uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  CPU-side UART transmitter: the outbound counterpart of the program-loading UART receiver.
//  Bytes are written by the store path of the CPU into a small FIFO.
//  Each byte is serialised on 'tx' as an 8N1 frame (start, 8 data LSB-first, stop).
//  Lets programs loaded over UART report results back to the host without stalling the core.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    8    entries in byte FIFO; power of two, >= 2
// PORTS
//  clk        in   1               system clock, all state on rising edge
//  rst        in   1               asynchronous, active-low reset (0 = reset)
//  wr_en      in   1               push wr_data this cycle
//  wr_data    in   8               byte to transmit
//  ovf_clr    in   1               clear sticky overflow flag
//  full       out  1               FIFO holds FIFO_DEPTH entries
//  empty      out  1               FIFO holds 0 entries
//  level      out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow   out  1               sticky: a write was dropped while full
//  tx_busy    out  1               FSM not IDLE (frame in progress)
//  tx         out  1               serial line, idles high
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, FSM=IDLE, FIFO empty (level=0, empty=1, full=0).
//   Also: overflow=0, tx_busy=0, bit/baud counters=0. Reset mid-frame aborts immediately; tx returns high.
//  FIFO: wr_en && !full -> byte stored, level+1 at next edge.
//   wr_en && full -> byte dropped, overflow set at next edge. Dropped even if a pop occurs the same cycle.
//   Pointers wrap modulo FIFO_DEPTH.
//   Simultaneous push (not full) + pop: level unchanged, data order preserved.
//  overflow: set wins over ovf_clr in the same cycle.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: tx=1. If !empty at edge E: pop head into shift reg, go START.
//     tx=0 from edge E. So a byte written at edge N into an empty FIFO drives the start bit from edge N+1.
//   START: hold tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//   DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right; after bit 7 go STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles. Then:
//     if !empty: pop and go START on the same edge (back-to-back frames, no extra idle cycle);
//     else go IDLE.
//  Frame length exactly 10*CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1.
//  tx_busy = (state != IDLE); tx registered (no combinational glitches).
//  Writes during a frame never disturb the byte being shifted.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset: rst=0 mid-frame -> tx=1, level=0, tx_busy=0, overflow=0 asynchronously.
//  2 Write 0xA5 once -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//    Start bit begins 1 edge after the write; tx_busy falls 40 cycles after start.
//  3 Write 0x01,0x80 back-to-back:
//    second start bit immediately follows first stop bit (no gap); 80 cycles total busy.
//  4 Write 6 bytes in consecutive cycles while idle:
//    first pops, next 4 fill FIFO (full=1), 6th dropped, overflow=1;
//    5 frames transmitted in order.
//  5 ovf_clr and a full-FIFO wr_en asserted in the same cycle -> overflow stays 1.
//    ovf_clr alone next cycle -> overflow=0.
//  6 Push+pop in the same cycle at level=2 -> level stays 2; transmitted order matches write order.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo_if : CPU write port and status/serial bundle          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               wr_en;
  logic [7:0]         wr_data;
  logic               ovf_clr;
  logic               full;
  logic               empty;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               tx_busy;
  logic               tx;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  full, empty, level, overflow, tx_busy, tx
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output full, empty, level, overflow, tx_busy, tx
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO feeding an 8N1 serial transmitter         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int c_addr_w  = $clog2(FIFO_DEPTH);
  localparam int c_level_w = c_addr_w + 1;
  localparam int c_baud_w  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0]  c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_level_w-1:0] c_depth     = c_level_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_level_w-1:0] r_count;
  logic                 r_overflow;
  state_t               r_state;
  logic [c_baud_w-1:0]  r_baud;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_baud_done;

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.wr_en && !w_full;
  assign w_baud_done = (r_baud == c_baud_last);
  // The FSM takes a byte whenever it is idle or finishing a stop bit.
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_level_w'(1);
        2'b01:   r_count <= r_count - c_level_w'(1);
        default: r_count <= r_count;
      endcase
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        ST_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              // Back-to-back frame: start bit follows the stop bit directly.
              r_shift <= r_mem[r_rd_ptr];
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.level    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.tx_busy  = (r_state != ST_IDLE);
  assign bus.tx       = r_tx;
endmodule
`default_nettype wire
